// File: rtl/hazard_branch_sched.sv
// hazard_branch_sched
// Pipeline scheduler for the static 5-stage MIPS core. Decides every cycle
// whether the PC and IF/ID advance, hold, or are redirected/flushed, and
// whether ID/EX gets a bubble or the back half of the pipe freezes.
//
// Handshake semantics: imem_ready=1 means the fetch of the current PC
// completes this cycle, so the PC may advance (or be redirected) on the next
// edge. dmem_req=1 with dmem_ready=0 means the MEM-stage access is still
// outstanding, so the pipe holds. A request and its ready are sampled in the
// same cycle; there is no separate acceptance phase.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   id_*                         ID-stage instruction and operand usage
//   ex_*, mem_*                  producer info for hazard detection
//   branch, wb_pc                redirect request and target from ID
//   imem_ready, dmem_req/ready   memory handshakes
//   pc_we, pc_sel, pc_redirect   PC update controls
//   if_id_we, if_id_flush        IF/ID register controls
//   id_ex_bubble, pipe_freeze    downstream register controls
//   dmem_timeout                 sticky data-memory timeout flag
//   stall_cnt, flush_cnt         saturating statistics
module hazard_branch_sched #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_ctrl,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dest,
  input  logic             mem_valid,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             branch,
  input  logic [31:0]      wb_pc,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      pc_redirect,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {RUN, REDIR_PEND} state_t;

  state_t            state;
  logic [31:0]       target_q;
  logic [WAIT_W-1:0] wait_cnt;

  logic [4:0] rs, rt;
  logic       m_rs, m_rt;
  logic       ex_match, mem_match;
  logic       load_use, br_use, hz, freeze;
  logic       stall_evt, flush_evt, go_pend, leave_pend;
  logic       unused_bits;

  assign rs = id_inst[25:21];
  assign rt = id_inst[20:16];
  assign unused_bits = ^{id_inst[31:26], id_inst[15:0]};

  // Register 0 is hardwired, so reading it can never depend on a producer.
  assign m_rs = id_uses_rs & (rs != 5'd0);
  assign m_rt = id_uses_rt & (rt != 5'd0);

  assign ex_match  = (m_rs & (ex_dest == rs))  | (m_rt & (ex_dest == rt));
  assign mem_match = (m_rs & (mem_dest == rs)) | (m_rt & (mem_dest == rt));

  assign load_use = id_valid & ex_valid & ex_mem_read & ex_match;
  // Control instructions read operands in ID, so any EX result and any
  // MEM-stage load result are still too late for them.
  assign br_use   = id_valid & id_is_ctrl &
                    ((ex_valid & ex_reg_write & ex_match) |
                     (mem_valid & mem_mem_read & mem_match));
  assign hz       = load_use | br_use;
  assign freeze   = dmem_req & ~dmem_ready;

  always_comb begin
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    pc_redirect  = wb_pc;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;
    go_pend      = 1'b0;
    leave_pend   = 1'b0;
    if (!resetn) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state == REDIR_PEND) begin
      // Keep steering the PC at the latched target and discard whatever
      // wrong-path fetch lands in IF/ID until the fetch completes.
      pc_sel      = 1'b1;
      pc_redirect = target_q;
      if_id_flush = 1'b1;
      if (freeze) begin
        pipe_freeze = 1'b1;
      end else begin
        if_id_we = 1'b1;
        if (imem_ready) begin
          pc_we      = 1'b1;
          leave_pend = 1'b1;
        end
      end
    end else begin
      if (freeze) begin
        pipe_freeze = 1'b1;
      end else if (hz) begin
        id_ex_bubble = 1'b1;
        stall_evt    = 1'b1;
      end else if (branch && id_valid) begin
        pc_sel      = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        flush_evt   = 1'b1;
        if (imem_ready) pc_we = 1'b1;
        else            go_pend = 1'b1;
      end else begin
        pc_we       = imem_ready;
        if_id_we    = 1'b1;
        if_id_flush = ~imem_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RUN;
      target_q     <= 32'd0;
      wait_cnt     <= '0;
      dmem_timeout <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      if (go_pend) begin
        state    <= REDIR_PEND;
        target_q <= wb_pc;
      end else if (leave_pend) begin
        state <= RUN;
      end

      if (freeze) begin
        if (wait_cnt != WAIT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) dmem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_branch_sched.sv
module tb_hazard_branch_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_ctrl;
  logic [31:0] id_inst;
  logic        ex_valid, ex_mem_read, ex_reg_write;
  logic [4:0]  ex_dest;
  logic        mem_valid, mem_mem_read;
  logic [4:0]  mem_dest;
  logic        branch;
  logic [31:0] wb_pc;
  logic        imem_ready, dmem_req, dmem_ready;

  logic        pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze, dmem_timeout;
  logic [31:0] pc_redirect;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_we, s_pc_sel, s_if_id_we, s_if_id_flush, s_id_ex_bubble, s_pipe_freeze, s_dmem_timeout;
  logic [31:0] s_pc_redirect;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_branch_sched u_dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_inst(id_inst),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_ctrl(id_is_ctrl),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .branch(branch), .wb_pc(wb_pc), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .pc_sel(pc_sel),
    .pc_redirect(pc_redirect), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_branch_sched #(.CNT_W(4)) u_sat (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_inst(id_inst),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_ctrl(id_is_ctrl),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .branch(branch), .wb_pc(wb_pc), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
    .pc_redirect(s_pc_redirect), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .pipe_freeze(s_pipe_freeze),
    .dmem_timeout(s_dmem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}
  logic [5:0] ctl;
  assign ctl = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze};

  typedef struct {
    logic       idv;
    logic [4:0] rs, rt;
    logic       urs, urt, ctrl;
    logic       exv, exmr, exrw;
    logic [4:0] exd;
    logic       memv, memmr;
    logic [4:0] memd;
    logic       br, imem, dreq, drdy;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vec[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_inst = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_ctrl = 0;
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0;
    mem_valid = 0; mem_mem_read = 0; mem_dest = 0;
    branch = 0; wb_pc = 32'h0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle();
    tick();
    resetn = 1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic ctrl);
    id_valid = 1; id_inst = {6'd0, rs, rt, 16'd0};
    id_uses_rs = urs; id_uses_rt = urt; id_is_ctrl = ctrl;
  endtask

  task automatic apply_vec(input vec_t v, input logic [31:0] pc);
    set_id(v.rs, v.rt, v.urs, v.urt, v.ctrl);
    id_valid = v.idv;
    ex_valid = v.exv; ex_mem_read = v.exmr; ex_reg_write = v.exrw; ex_dest = v.exd;
    mem_valid = v.memv; mem_mem_read = v.memmr; mem_dest = v.memd;
    branch = v.br; wb_pc = pc; imem_ready = v.imem; dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  initial begin
    //         idv rs rt urs urt ctl exv mr rw exd memv mmr md br im dq dr exp
    vec[0]  = '{1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "norm_imem1"};
    vec[1]  = '{1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001100, "norm_imem0"};
    vec[2]  = '{1, 8, 2, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 6'b000010, "lu_rs"};
    vec[3]  = '{1, 3, 8, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 6'b000010, "lu_rt"};
    vec[4]  = '{1, 3, 8, 1, 0, 0, 1, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "lu_rt_unused"};
    vec[5]  = '{1, 0, 2, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "lu_r0"};
    vec[6]  = '{1, 8, 2, 1, 1, 0, 0, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "lu_ex_inv"};
    vec[7]  = '{1, 9, 2, 1, 1, 1, 1, 0, 1, 9, 0, 0, 0, 1, 1, 0, 0, 6'b000010, "bu_ex"};
    vec[8]  = '{1, 9, 2, 1, 1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "alu_fwd"};
    vec[9]  = '{1, 4, 9, 1, 1, 1, 0, 0, 0, 0, 1, 1, 9, 1, 1, 0, 0, 6'b000010, "bu_mem"};
    vec[10] = '{1, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b111100, "br_taken"};
    vec[11] = '{0, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6'b101000, "br_noid"};
    vec[12] = '{1, 4, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6'b000001, "frz_br"};
    vec[13] = '{1, 8, 2, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, 0, 1, 1, 0, 6'b000001, "frz_lu"};
    vec[14] = '{1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b101000, "dmem_done"};
    vec[15] = '{0, 8, 2, 1, 1, 0, 1, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 6'b101000, "lu_noid"};
    vec[16] = '{1, 9, 2, 1, 1, 1, 0, 0, 0, 0, 1, 0, 9, 0, 1, 0, 0, 6'b101000, "bu_mem_alu"};

    // Reset: forced outputs while low, cleared state afterwards.
    resetn = 0;
    idle();
    set_id(5'd4, 5'd5, 1, 1, 1);
    branch = 1; wb_pc = 32'h0040_0040;
    tick();
    #1;
    chk("rst_ctl", {26'd0, ctl}, {26'd0, 6'b000110});
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
    chk("rst_tmo", {31'd0, dmem_timeout}, 32'd0);
    resetn = 1;

    // Single-cycle decisions from RUN.
    for (int i = 0; i < 17; i++) begin
      do_reset();
      apply_vec(vec[i], 32'h0040_0000 + 32'(i * 16));
      #1;
      chk({"vec_ctl_", vec[i].name}, {26'd0, ctl}, {26'd0, vec[i].exp});
      chk({"vec_pcr_", vec[i].name}, pc_redirect, 32'h0040_0000 + 32'(i * 16));
      tick();
    end

    // Load-use: one stall cycle then normal flow.
    do_reset();
    set_id(5'd8, 5'd2, 1, 1, 0);
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd8;
    #1;
    chk("lu_stall_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
    tick();
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
    #1;
    chk("lu_after_ctl", {26'd0, ctl}, {26'd0, 6'b101000});
    tick();
    chk("lu_after_cnt", {16'd0, stall_cnt}, 32'd1);

    // BEQ on r9: EX producer, then MEM load, then redirect.
    do_reset();
    set_id(5'd9, 5'd0, 1, 1, 1);
    branch = 1; wb_pc = 32'h0040_0020;
    ex_valid = 1; ex_reg_write = 1; ex_dest = 5'd9;
    #1;
    chk("beq_ex_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
    tick();
    ex_valid = 0; ex_reg_write = 0;
    mem_valid = 1; mem_mem_read = 1; mem_dest = 5'd9;
    #1;
    chk("beq_mem_ctl", {26'd0, ctl}, {26'd0, 6'b000010});
    tick();
    chk("beq_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    chk("beq_flush_cnt0", {16'd0, flush_cnt}, 32'd0);
    mem_valid = 0; mem_mem_read = 0;
    #1;
    chk("beq_taken_ctl", {26'd0, ctl}, {26'd0, 6'b111100});
    chk("beq_taken_pc", pc_redirect, 32'h0040_0020);
    tick();
    chk("beq_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Redirect while fetch outstanding.
    do_reset();
    set_id(5'd4, 5'd5, 1, 1, 1);
    branch = 1; wb_pc = 32'h0040_0100; imem_ready = 0;
    #1;
    chk("pend_enter_ctl", {26'd0, ctl}, {26'd0, 6'b011100});
    tick();
    branch = 0; wb_pc = 32'hdead_beef;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("pend_wait_ctl", {26'd0, ctl}, {26'd0, 6'b011100});
      chk("pend_wait_pc", pc_redirect, 32'h0040_0100);
      tick();
      wb_pc = 32'h1234_5678;
    end
    imem_ready = 1;
    #1;
    chk("pend_done_ctl", {26'd0, ctl}, {26'd0, 6'b111100});
    chk("pend_done_pc", pc_redirect, 32'h0040_0100);
    tick();
    #1;
    chk("pend_run_ctl", {26'd0, ctl}, {26'd0, 6'b101000});
    chk("pend_run_pc", pc_redirect, 32'h1234_5678);
    chk("pend_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Freeze beats branch; branch taken on release; timeout.
    do_reset();
    set_id(5'd4, 5'd5, 1, 1, 1);
    branch = 1; wb_pc = 32'h0040_0200; dmem_req = 1; dmem_ready = 0;
    #1;
    chk("frz_br_ctl", {26'd0, ctl}, {26'd0, 6'b000001});
    tick();
    chk("frz_br_flush0", {16'd0, flush_cnt}, 32'd0);
    dmem_ready = 1;
    #1;
    chk("frz_rel_ctl", {26'd0, ctl}, {26'd0, 6'b111100});
    tick();
    chk("frz_rel_flush", {16'd0, flush_cnt}, 32'd1);
    branch = 0; dmem_ready = 0;
    repeat (200) tick();
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    repeat (254) tick();
    chk("tmo_254", {31'd0, dmem_timeout}, 32'd0);
    tick();
    chk("tmo_255", {31'd0, dmem_timeout}, 32'd1);
    dmem_req = 0;
    repeat (3) tick();
    chk("tmo_sticky", {31'd0, dmem_timeout}, 32'd1);
    chk("tmo_stall0", {16'd0, stall_cnt}, 32'd0);

    // Saturation with the narrow-counter instance.
    do_reset();
    set_id(5'd8, 5'd2, 1, 1, 0);
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd8;
    repeat (20) tick();
    chk("sat_stall4", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat_stall16", {16'd0, stall_cnt}, 32'd20);

    // Reset in the middle of a pending redirect.
    do_reset();
    set_id(5'd4, 5'd5, 1, 1, 1);
    branch = 1; wb_pc = 32'h0040_0300; imem_ready = 0;
    tick();
    branch = 0; resetn = 0;
    #1;
    chk("rstpend_forced", {26'd0, ctl}, {26'd0, 6'b000110});
    tick();
    resetn = 1; imem_ready = 1; wb_pc = 32'h0040_0400;
    #1;
    chk("rstpend_ctl", {26'd0, ctl}, {26'd0, 6'b101000});
    chk("rstpend_pc", pc_redirect, 32'h0040_0400);
    chk("rstpend_flush", {16'd0, flush_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
